flow_32to8_pkt: RTL and testbench

Packet-aware vld/rdy downsizer: accepts 32-bit words with a valid-byte count and an end-of-packet flag, and emits them as a stream of 8-bit bytes, least-significant byte first, carrying the last flag on the final byte of a packet. It is the narrow-side reader for a packed word stream. It sits between a wide master (or an upsizer output) and an 8-bit consumer, and sustains one byte per cycle with back-to-back words.

---
 rtl/flow_32to8_pkt.sv | 98 +++++++++
 tb/tb_flow_32to8_pkt.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_32to8_pkt.sv
// Packet-aware 32-to-8 downsizer: one held word drained LSB byte first, last flag on its final byte.
// Latency 1 cycle from word acceptance to byte 0; src_rdy depends combinationally on dst_rdy.
module flow_32to8_pkt #(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4,
    parameter int CNTW   = 16,
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en,
    input  logic                     src_val,
    output logic                     src_rdy,
    input  logic [DWIDTH*RATIO-1:0]  src_data,
    input  logic [BW-1:0]            src_bcnt,
    input  logic                     src_last,
    output logic                     dst_val,
    input  logic                     dst_rdy,
    output logic [DWIDTH-1:0]        dst_data,
    output logic                     dst_last,
    output logic [CNTW-1:0]          pkt_cnt
);

    logic [DWIDTH*RATIO-1:0] word_q, word_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic                    last_q, last_d;
    logic [BW-1:0]           idx_q, idx_d;
    logic                    full_q, full_d;
    logic [CNTW-1:0]         pkt_cnt_q, pkt_cnt_d;

    logic [DWIDTH-1:0]       word_bytes [RATIO];
    logic                    final_byte;
    logic                    in_hs;
    logic                    out_hs;

    for (genvar k = 0; k < RATIO; k++) begin : g_bytes
        assign word_bytes[k] = word_q[k*DWIDTH +: DWIDTH];
    end

    assign final_byte = (idx_q == bcnt_q);

    // A new word may land on the same edge the held word's final byte leaves.
    assign src_rdy  = cfg_en && !rst && (!full_q || (dst_rdy && final_byte));
    assign in_hs    = src_val && src_rdy;
    assign out_hs   = full_q && dst_rdy;

    assign dst_val  = full_q;
    assign dst_data = full_q ? word_bytes[idx_q] : '0;
    assign dst_last = full_q && last_q && final_byte;
    assign pkt_cnt  = pkt_cnt_q;

    always_comb begin
        word_d    = word_q;
        bcnt_d    = bcnt_q;
        last_d    = last_q;
        idx_d     = idx_q;
        full_d    = full_q;
        pkt_cnt_d = pkt_cnt_q;

        if (out_hs) begin
            if (final_byte) begin
                full_d = 1'b0;
            end else begin
                idx_d = idx_q + BW'(1);
            end
            if (dst_last) begin
                pkt_cnt_d = pkt_cnt_q + CNTW'(1);
            end
        end

        if (in_hs) begin
            word_d = src_data;
            bcnt_d = src_bcnt;
            last_d = src_last;
            idx_d  = '0;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            bcnt_q    <= '0;
            last_q    <= 1'b0;
            idx_q     <= '0;
            full_q    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            word_q    <= word_d;
            bcnt_q    <= bcnt_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            full_q    <= full_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_flow_32to8_pkt.sv
// Scoreboard bench for flow_32to8_pkt: stimulus pushes expected bytes, a negedge monitor pops and checks.
module tb_flow_32to8_pkt;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic        src_val;
    logic        src_rdy;
    logic [31:0] src_data;
    logic [1:0]  src_bcnt;
    logic        src_last;
    logic        dst_val;
    logic        dst_rdy;
    logic [7:0]  dst_data;
    logic        dst_last;
    logic [15:0] pkt_cnt;

    flow_32to8_pkt #(.DWIDTH(8), .RATIO(4), .CNTW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_en   (cfg_en),
        .src_val  (src_val),
        .src_rdy  (src_rdy),
        .src_data (src_data),
        .src_bcnt (src_bcnt),
        .src_last (src_last),
        .dst_val  (dst_val),
        .dst_rdy  (dst_rdy),
        .dst_data (dst_data),
        .dst_last (dst_last),
        .pkt_cnt  (pkt_cnt)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t        sbq[$];
    int          out_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] exp_pkt = '0;
    int          rdy_mode = 0;
    int          rdy_phase = 0;
    logic        cfg_force = 1'b1;
    logic        cfg_rand = 1'b0;
    logic        cfg_rnd_bit = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    assign cfg_en = cfg_force && (!cfg_rand || cfg_rnd_bit);

    // Sink-side ready: 0 = always ready, 1 = repeating 1,0,0 stalls, 2 = random.
    initial begin
        dst_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       begin dst_rdy = (rdy_phase == 0); rdy_phase = (rdy_phase + 1) % 3; end
                2:       dst_rdy = ($urandom_range(0, 99) < 65);
                default: dst_rdy = 1'b1;
            endcase
            cfg_rnd_bit = ($urandom_range(0, 99) < 80);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: the expected ready and valid come from how many bytes of the held word remain.
    initial begin
        logic [7:0] prev_d;
        logic       prev_l;
        logic       stalled;
        logic       exp_rdy;
        exp_t       e;
        stalled = 1'b0;
        prev_d  = '0;
        prev_l  = 1'b0;
        forever begin
            @(negedge clk);
            exp_rdy = cfg_en && !rst && (sbq.size() == 0 || (dst_rdy && sbq.size() == 1));
            chk("src_rdy", {31'd0, src_rdy}, {31'd0, exp_rdy});
            if (rst) begin
                sbq.delete();
                exp_pkt = '0;
                stalled = 1'b0;
            end else begin
                chk("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, exp_pkt});
                chk("dst_val", {31'd0, dst_val}, {31'd0, sbq.size() != 0});
                if (!dst_val) begin
                    chk("idle_data", {24'd0, dst_data}, 32'd0);
                    chk("idle_last", {31'd0, dst_last}, 32'd0);
                end
                if (stalled && dst_val) begin
                    chk("stall_data", {24'd0, dst_data}, {24'd0, prev_d});
                    chk("stall_last", {31'd0, dst_last}, {31'd0, prev_l});
                end
                if (dst_val && dst_rdy && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("dst_data", {24'd0, dst_data}, {24'd0, e.d});
                    chk("dst_last", {31'd0, dst_last}, {31'd0, e.l});
                    if (e.l) exp_pkt = exp_pkt + 16'd1;
                    out_cyc.push_back(cyc);
                end
                stalled = dst_val && !dst_rdy;
                prev_d  = dst_data;
                prev_l  = dst_last;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic [1:0] b, input logic l,
                             input bit keep, output int acc);
        bit ok;
        exp_t e;
        ok       = 1'b0;
        acc      = -1;
        src_val  = 1'b1;
        src_data = d;
        src_bcnt = b;
        src_last = l;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            #1;
            if (src_rdy) begin
                ok  = 1'b1;
                acc = cyc;
                for (int k = 0; k <= int'(b); k++) begin
                    e.d = d[k*8 +: 8];
                    e.l = l && (k == int'(b));
                    sbq.push_back(e);
                end
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no src_rdy, expected acceptance of 0x%08h", d);
        end
        @(posedge clk);
        #1;
        if (!keep) src_val = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0 && !dst_val) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d bytes pending, expected 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_a;
        int acc_b;
        logic [15:0] p0;
        logic [31:0] w;

        rst      = 1'b1;
        src_val  = 1'b0;
        src_data = '0;
        src_bcnt = '0;
        src_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_dst_val", {31'd0, dst_val}, 32'd0);
        chk("rst_dst_data", {24'd0, dst_data}, 32'd0);
        chk("rst_dst_last", {31'd0, dst_last}, 32'd0);
        chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        chk("rst_src_rdy", {31'd0, src_rdy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("empty_src_rdy", {31'd0, src_rdy}, 32'd1);
        @(posedge clk);
        #1;

        // Single full word, sink always ready.
        out_cyc.delete();
        send_word(32'h44332211, 2'd3, 1'b1, 1'b0, acc_a);
        wait_drain(50);
        chk("single_nbytes", out_cyc.size(), 32'd4);
        if (out_cyc.size() == 4) begin
            chk("single_latency", out_cyc[0], acc_a + 1);
            chk("single_span", out_cyc[3], acc_a + 4);
        end
        chk("single_pkt", {16'd0, pkt_cnt}, 32'd1);

        // Partial word followed back-to-back by a one-byte last word.
        out_cyc.delete();
        send_word(32'hDDCCBBAA, 2'd1, 1'b0, 1'b1, acc_a);
        send_word(32'h00000077, 2'd0, 1'b1, 1'b0, acc_b);
        wait_drain(50);
        chk("b2b_nbytes", out_cyc.size(), 32'd3);
        if (out_cyc.size() == 3) begin
            chk("b2b_first", out_cyc[0], acc_a + 1);
            chk("b2b_load_on_final", acc_b, out_cyc[1]);
            chk("b2b_no_gap", out_cyc[2], out_cyc[0] + 2);
        end

        // Backpressure with the 1,0,0 ready pattern.
        rdy_mode = 1;
        out_cyc.delete();
        send_word(32'h44332211, 2'd3, 1'b1, 1'b0, acc_a);
        wait_drain(100);
        chk("bp_nbytes", out_cyc.size(), 32'd4);
        rdy_mode = 0;

        // Enable dropped right after acceptance: held word drains, pending word waits.
        send_word(32'h8C8B8A89, 2'd3, 1'b1, 1'b0, acc_a);
        cfg_force = 1'b0;
        src_val   = 1'b1;
        src_data  = 32'h5A5A5A5A;
        src_bcnt  = 2'd2;
        src_last  = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("gate_src_rdy", {31'd0, src_rdy}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("gate_drained", sbq.size(), 32'd0);
        cfg_force = 1'b1;
        send_word(32'h5A5A5A5A, 2'd2, 1'b1, 1'b0, acc_a);
        wait_drain(50);

        // Reset after two bytes of a four-byte word have left.
        out_cyc.delete();
        send_word(32'hF4F3F2F1, 2'd3, 1'b1, 1'b0, acc_a);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            if (out_cyc.size() >= 2) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_dst_val", {31'd0, dst_val}, 32'd0);
        chk("mid_rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        @(posedge clk);
        #1;
        send_word(32'h0D0C0B0A, 2'd3, 1'b1, 1'b0, acc_a);
        wait_drain(50);

        // Random words with random gaps, random sink stalls and random enable.
        rdy_mode = 2;
        cfg_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            send_word(w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0), acc_a);
            if ($urandom_range(0, 4) == 0) begin
                src_val = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        src_val = 1'b0;
        cfg_rand = 1'b0;
        wait_drain(500);
        rdy_mode = 0;

        // 65536 single-byte packets must bring the counter back to its start value.
        p0 = pkt_cnt;
        for (int i = 0; i < 65536; i++) begin
            send_word($urandom, 2'd0, 1'b1, (i != 65535), acc_a);
        end
        wait_drain(50);
        chk("wrap_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, p0});
        send_word(32'h000000EE, 2'd0, 1'b1, 1'b0, acc_a);
        wait_drain(50);
        chk("wrap_continue", {16'd0, pkt_cnt}, {16'd0, p0 + 16'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
